// File: rtl/rll_key_sequencer.sv
// Serial key loader and vector sequencer for a logic-locked circuit: shifts in the key,
// applies vectors, waits a fixed settle time and hands back the captured response.
module rll_key_sequencer #(
    parameter int unsigned KEY_W  = 32,
    parameter int unsigned VEC_W  = 32,
    parameter int unsigned SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_start,
    input  logic             key_bit,
    input  logic             key_bit_valid,
    output logic             key_bit_ready,
    output logic             key_loaded,
    input  logic [VEC_W-1:0] vec_data,
    input  logic             vec_valid,
    output logic             vec_ready,
    output logic [VEC_W-1:0] circ_in,
    output logic [KEY_W-1:0] circ_key,
    input  logic [VEC_W-1:0] circ_out,
    output logic [VEC_W-1:0] res_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      vec_count
);

    localparam int unsigned      CNT_W     = $clog2(KEY_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(KEY_W - 1);
    localparam logic [3:0]       SETTLE_M1 = 4'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READY,
        S_SETTLE,
        S_RESP
    } state_t;

    state_t             state_q;
    logic [KEY_W-1:0]   key_sr_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [3:0]         settle_cnt_q;
    logic               key_loaded_q;
    logic               kbr_q;
    logic               rdy_q;
    logic [VEC_W-1:0]   circ_in_q;
    logic [VEC_W-1:0]   res_data_q;
    logic               res_valid_q;
    logic [15:0]        vec_count_q;

    logic               restart;

    // A load request is honoured only where a key may be (re)loaded; it outranks key bits and vectors.
    assign restart = load_start && (state_q inside {S_IDLE, S_LOAD, S_READY});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            key_sr_q     <= '0;
            bit_cnt_q    <= '0;
            settle_cnt_q <= '0;
            key_loaded_q <= 1'b0;
            kbr_q        <= 1'b0;
            rdy_q        <= 1'b0;
            circ_in_q    <= '0;
            res_data_q   <= '0;
            res_valid_q  <= 1'b0;
            vec_count_q  <= '0;
        end else if (restart) begin
            key_sr_q     <= '0;
            bit_cnt_q    <= '0;
            key_loaded_q <= 1'b0;
            kbr_q        <= 1'b1;
            rdy_q        <= 1'b0;
            state_q      <= S_LOAD;
        end else begin
            case (state_q)
                S_IDLE: ;
                S_LOAD: begin
                    if (key_bit_valid) begin
                        key_sr_q  <= {key_sr_q[KEY_W-2:0], key_bit};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAST_BIT) begin
                            key_loaded_q <= 1'b1;
                            kbr_q        <= 1'b0;
                            rdy_q        <= 1'b1;
                            state_q      <= S_READY;
                        end
                    end
                end
                S_READY: begin
                    if (vec_valid) begin
                        circ_in_q    <= vec_data;
                        settle_cnt_q <= SETTLE_M1;
                        rdy_q        <= 1'b0;
                        state_q      <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt_q == 4'd0) begin
                        res_data_q  <= circ_out;
                        res_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        settle_cnt_q <= settle_cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        vec_count_q <= vec_count_q + 16'd1;
                        rdy_q       <= 1'b1;
                        state_q     <= S_READY;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign key_bit_ready = kbr_q;
    assign key_loaded    = key_loaded_q;
    assign vec_ready     = rdy_q & ~load_start;
    assign circ_in       = circ_in_q;
    assign circ_key      = key_loaded_q ? key_sr_q : '0;
    assign res_data      = res_data_q;
    assign res_valid     = res_valid_q;
    assign vec_count     = vec_count_q;

endmodule

// File: tb/tb_rll_key_sequencer.sv
// Directed bench for rll_key_sequencer: key loading, restart, vector handshake,
// back-pressure, mid-operation reset and response counter wrap.
module tb_rll_key_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic        key_bit;
    logic        key_bit_valid;
    logic        key_bit_ready;
    logic        key_loaded;
    logic [31:0] vec_data;
    logic        vec_valid;
    logic        vec_ready;
    logic [31:0] circ_in;
    logic [31:0] circ_key;
    logic [31:0] circ_out;
    logic [31:0] res_data;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] vec_count;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    rll_key_sequencer #(.KEY_W(32), .VEC_W(32), .SETTLE(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .load_start    (load_start),
        .key_bit       (key_bit),
        .key_bit_valid (key_bit_valid),
        .key_bit_ready (key_bit_ready),
        .key_loaded    (key_loaded),
        .vec_data      (vec_data),
        .vec_valid     (vec_valid),
        .vec_ready     (vec_ready),
        .circ_in       (circ_in),
        .circ_key      (circ_key),
        .circ_out      (circ_out),
        .res_data      (res_data),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .vec_count     (vec_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shifts nbits of key MSB-first, with one idle cycle after bit 10.
    task automatic shift_key(input logic [31:0] key, input int unsigned nbits);
        for (int unsigned i = 0; i < nbits; i++) begin
            if (i == 10) begin
                key_bit_valid = 1'b0;
                key_bit       = 1'b1;
                tick();
            end
            key_bit       = key[31-i];
            key_bit_valid = 1'b1;
            tick();
            if (i == 30) check("key_loaded_after_31", {63'd0, key_loaded}, 64'd0);
        end
        key_bit_valid = 1'b0;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic run_txn(input logic [31:0] vec, input logic [31:0] resp,
                           input logic [15:0] exp_count);
        int unsigned waited;
        circ_out  = resp;
        vec_data  = vec;
        vec_valid = 1'b1;
        tick();
        vec_valid = 1'b0;
        waited    = 0;
        while (!res_valid && waited < 20) begin
            tick();
            waited++;
        end
        check("txn_res_valid", {63'd0, res_valid}, 64'd1);
        check("txn_res_data", {32'd0, res_data}, {32'd0, resp});
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("txn_vec_count", {48'd0, vec_count}, {48'd0, exp_count});
    endtask

    initial begin
        rst = 1'b1; load_start = 1'b0; key_bit = 1'b0; key_bit_valid = 1'b0;
        vec_data = '0; vec_valid = 1'b0; circ_out = '0; res_ready = 1'b0;
        tick(); tick();
        check("rst_key_bit_ready", {63'd0, key_bit_ready}, 64'd0);
        check("rst_key_loaded", {63'd0, key_loaded}, 64'd0);
        check("rst_vec_ready", {63'd0, vec_ready}, 64'd0);
        check("rst_res_valid", {63'd0, res_valid}, 64'd0);
        check("rst_circ_key", {32'd0, circ_key}, 64'd0);
        check("rst_vec_count", {48'd0, vec_count}, 64'd0);
        rst = 1'b0;

        // Key load of 0xA5C30F96
        start_load();
        check("load_kbr", {63'd0, key_bit_ready}, 64'd1);
        check("load_vec_ready", {63'd0, vec_ready}, 64'd0);
        shift_key(32'hA5C3_0F96, 32);
        check("key_loaded", {63'd0, key_loaded}, 64'd1);
        check("circ_key_a5", {32'd0, circ_key}, 64'hA5C3_0F96);
        check("kbr_after_load", {63'd0, key_bit_ready}, 64'd0);
        check("vec_ready_ready", {63'd0, vec_ready}, 64'd1);

        // Vector handshake, latency SETTLE+1
        circ_out  = 32'hDEAD_BEEF;
        vec_data  = 32'h1234_5678;
        vec_valid = 1'b1;
        tick();
        vec_valid = 1'b0;
        check("circ_in_applied", {32'd0, circ_in}, 64'h1234_5678);
        check("lat_c1_res_valid", {63'd0, res_valid}, 64'd0);
        check("settle_vec_ready", {63'd0, vec_ready}, 64'd0);
        tick();
        check("lat_c2_res_valid", {63'd0, res_valid}, 64'd0);
        tick();
        check("lat_c3_res_valid", {63'd0, res_valid}, 64'd1);
        check("res_data_beef", {32'd0, res_data}, 64'hDEAD_BEEF);

        // Back-pressure: outputs hold, vectors and load_start ignored
        circ_out  = 32'h0BAD_F00D;
        vec_data  = 32'hCAFE_0001;
        vec_valid = 1'b1;
        for (int unsigned i = 0; i < 10; i++) begin
            load_start = (i == 4);
            tick();
            check("stall_res_data", {32'd0, res_data}, 64'hDEAD_BEEF);
            check("stall_res_valid", {63'd0, res_valid}, 64'd1);
            check("stall_vec_ready", {63'd0, vec_ready}, 64'd0);
        end
        load_start = 1'b0;
        vec_valid  = 1'b0;
        check("stall_circ_in", {32'd0, circ_in}, 64'h1234_5678);
        check("stall_key_loaded", {63'd0, key_loaded}, 64'd1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("vec_count_1", {48'd0, vec_count}, 64'd1);
        check("resp_res_valid", {63'd0, res_valid}, 64'd0);
        check("back_vec_ready", {63'd0, vec_ready}, 64'd1);

        // load_start in READY outranks a pending vector
        vec_data   = 32'h7777_7777;
        vec_valid  = 1'b1;
        load_start = 1'b1;
        #1;
        check("vec_ready_gated", {63'd0, vec_ready}, 64'd0);
        tick();
        load_start = 1'b0;
        vec_valid  = 1'b0;
        check("reload_circ_in", {32'd0, circ_in}, 64'h1234_5678);
        check("reload_key_loaded", {63'd0, key_loaded}, 64'd0);
        check("reload_circ_key", {32'd0, circ_key}, 64'd0);

        // Abort after 17 bits, restart with a simultaneous key bit, then full load
        shift_key(32'hB3E1_7A5D, 17);
        load_start    = 1'b1;
        key_bit       = 1'b1;
        key_bit_valid = 1'b1;
        tick();
        load_start    = 1'b0;
        key_bit_valid = 1'b0;
        check("restart_kbr", {63'd0, key_bit_ready}, 64'd1);
        shift_key(32'hFFFF_0000, 32);
        check("circ_key_ffff", {32'd0, circ_key}, 64'hFFFF_0000);

        // Reset during SETTLE
        vec_data  = 32'h55AA_55AA;
        vec_valid = 1'b1;
        tick();
        vec_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_circ_key", {32'd0, circ_key}, 64'd0);
        check("mid_rst_circ_in", {32'd0, circ_in}, 64'd0);
        check("mid_rst_res_valid", {63'd0, res_valid}, 64'd0);
        check("mid_rst_res_data", {32'd0, res_data}, 64'd0);
        check("mid_rst_vec_count", {48'd0, vec_count}, 64'd0);
        check("mid_rst_key_loaded", {63'd0, key_loaded}, 64'd0);
        check("mid_rst_kbr", {63'd0, key_bit_ready}, 64'd0);
        vec_valid = 1'b1;
        tick();
        vec_valid = 1'b0;
        check("idle_vec_ignored", {32'd0, circ_in}, 64'd0);
        check("idle_res_valid", {63'd0, res_valid}, 64'd0);

        // Counter wrap: preset stands in for 65534 earlier transactions
        start_load();
        shift_key(32'h0F0F_1234, 32);
        check("wrap_key", {32'd0, circ_key}, 64'h0F0F_1234);
        run_txn(32'h0000_0001, 32'h1111_2222, 16'd1);
        force dut.vec_count_q = 16'hFFFE;
        #2;
        release dut.vec_count_q;
        #1;
        check("preset_count", {48'd0, vec_count}, 64'hFFFE);
        run_txn(32'h0000_0002, 32'h3333_4444, 16'hFFFF);
        run_txn(32'h0000_0003, 32'h5555_6666, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rll_key_sequencer.md
RLL_KEY_SEQUENCER -- requirements
Module: rll_key_sequencer

Interface
REQ-001 Parameter KEY_W, default 32: width of the key register and the circ_key bus.
REQ-002 Parameter VEC_W, default 32: width of the circ_in, circ_out, vec_data and res_data buses.
REQ-003 Parameter SETTLE, default 2, legal range 1..15: cycles between applying a vector and capturing circ_out.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 load_start  in  1  pulse; begins a serial key load.
REQ-007 key_bit  in  1  serial key data, MSB first.
REQ-008 key_bit_valid  in  1  key_bit is valid this cycle.
REQ-009 key_bit_ready  out  1  block accepts key bits.
REQ-010 key_loaded  out  1  a complete key is held.
REQ-011 vec_data  in  VEC_W  input vector for the locked circuit.
REQ-012 vec_valid  in  1  vec_data is valid.
REQ-013 vec_ready  out  1  block accepts a vector.
REQ-014 circ_in  out  VEC_W  registered primary inputs to the locked circuit.
REQ-015 circ_key  out  KEY_W  key inputs to the locked circuit.
REQ-016 circ_out  in  VEC_W  combinational primary outputs of the locked circuit.
REQ-017 res_data  out  VEC_W  captured circ_out.
REQ-018 res_valid  out  1  res_data is valid.
REQ-019 res_ready  in  1  consumer accepts res_data.
REQ-020 vec_count  out  16  number of completed responses; wraps from 0xFFFF to 0.

Function
REQ-021 The FSM SHALL have the states IDLE, LOAD, READY, SETTLE and RESP.
REQ-022 In IDLE or READY, load_start=1 SHALL clear the shift register, the bit counter and key_loaded, then enter LOAD.
REQ-023 In LOAD, key_bit_ready SHALL be 1; each cycle with key_bit_valid=1 SHALL shift key_sr <= {key_sr[KEY_W-2:0], key_bit} and increment the bit counter.
REQ-024 Acceptance of bit KEY_W SHALL set key_loaded=1 and enter READY on the same edge.
REQ-025 load_start=1 in LOAD SHALL restart the load, clearing the bit counter and shift register; load_start SHALL take priority over a simultaneous key_bit_valid.
REQ-026 load_start SHALL be ignored in SETTLE and RESP.
REQ-027 circ_key SHALL equal key_sr when key_loaded=1 and all-zero otherwise.
REQ-028 vec_ready SHALL be 1 only in READY with load_start=0.
REQ-029 A handshake (vec_valid & vec_ready) SHALL register vec_data into circ_in, load the settle counter with SETTLE-1, and enter SETTLE.
REQ-030 SETTLE SHALL last exactly SETTLE cycles; on its last cycle circ_out SHALL be captured into res_data, res_valid set to 1, and RESP entered.
REQ-031 In RESP, res_valid and res_data SHALL hold until res_ready=1; that handshake SHALL increment vec_count and return to READY, with vec_ready rising on the next cycle.
REQ-032 The latency from vec handshake to res_valid=1 SHALL be SETTLE+1 cycles.
REQ-033 circ_in SHALL hold its last vector outside SETTLE.
REQ-034 Signals key_bit_valid, vec_valid and res_ready SHALL be ignored in states where they have no defined effect.

Reset
REQ-035 rst=1 SHALL, in any state and mid-operation, force: state IDLE; key_sr, the bit counter, the settle counter, circ_in, res_data and vec_count to 0; key_loaded, key_bit_ready, vec_ready and res_valid to 0; circ_key to 0.
REQ-036 rst SHALL take priority over every other input in the same cycle.

Verification
REQ-037 Reset, load_start, then 32 bits of 0xA5C3_0F96 MSB first -> key_loaded=1 after the 32nd bit and circ_key=0xA5C30F96.
REQ-038 Loaded key, vec_data=0x12345678 handshake, SETTLE=2, circ_out driven 0xDEADBEEF -> res_valid asserts 3 cycles after the handshake with res_data=0xDEADBEEF; res_ready=1 gives vec_count=1.
REQ-039 res_ready held 0 for 10 cycles while in RESP -> res_data stable, vec_ready=0, vec_valid ignored.
REQ-040 load_start after 17 bits, then 32 bits of 0xFFFF_0000 -> circ_key=0xFFFF0000 and no residue from the first 17 bits.
REQ-041 rst pulsed during SETTLE -> next cycle IDLE, all outputs 0, circ_key=0, vec_count=0.
REQ-042 With vec_count preset by 65535 transactions, one more transaction -> vec_count=0.
